// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// Borrows the shared ALU for its adds (kADD) and carry detection (kLT).
package definitions;
    localparam logic [2:0] kADD = 3'b000;
    localparam logic [2:0] kLT  = 3'b011;
endpackage

module alu_mul_seq
    import definitions::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [7:0]  OpA,
    input  logic [7:0]  OpB,
    output logic        Ready,
    output logic        Done,
    output logic [15:0] Product,
    output logic [7:0]  AluA,
    output logic [7:0]  AluB,
    output logic [2:0]  AluOp,
    input  logic [7:0]  AluOut,
    input  logic        AluZero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_CARRY,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [7:0] m;
    logic [7:0] ph;
    logic [7:0] pl;
    logic [7:0] s;
    logic       c;
    logic [2:0] cnt;
    logic [7:0] ph_sh;
    logic [7:0] pl_sh;
    logic       unused_zero;

    assign unused_zero = AluZero;

    // {C,PH,PL} shifted right by one
    assign ph_sh = {c, ph[7:1]};
    assign pl_sh = {ph[0], pl[7:1]};

    assign Ready = (state == S_IDLE);
    assign Done  = (state == S_DONE);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        AluA    = 8'h00;
        AluB    = 8'h00;
        AluOp   = kADD;
        unique case (state)
            S_IDLE: begin
                if (Start) begin
                    state_n = OpB[0] ? S_ADD : S_SHIFT;
                end
            end
            S_ADD: begin
                AluA    = ph;
                AluB    = m;
                state_n = S_CARRY;
            end
            S_CARRY: begin
                // sum wrapped iff it ended up below the addend
                AluA    = s;
                AluB    = m;
                AluOp   = kLT;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt == 3'd7) begin
                    state_n = S_DONE;
                end else begin
                    state_n = pl_sh[0] ? S_ADD : S_SHIFT;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            m       <= 8'h00;
            ph      <= 8'h00;
            pl      <= 8'h00;
            s       <= 8'h00;
            c       <= 1'b0;
            cnt     <= 3'd0;
            Product <= 16'h0000;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (Start) begin
                        m   <= OpA;
                        ph  <= 8'h00;
                        pl  <= OpB;
                        cnt <= 3'd0;
                        c   <= 1'b0;
                    end
                end
                S_ADD: begin
                    s <= AluOut;
                end
                S_CARRY: begin
                    c  <= AluOut[0];
                    ph <= s;
                end
                S_SHIFT: begin
                    ph <= ph_sh;
                    pl <= pl_sh;
                    c  <= 1'b0;
                    if (cnt == 3'd7) begin
                        Product <= {ph_sh, pl_sh};
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
